pipe_hazard_ctrl: RTL

Sequencing controller for the five-stage pipeline's IF/ID and ID/EX registers and PC. Each cycle it computes PC write enable, IF/ID write enable, IF/ID flush, ID/EX flush and PC redirect. Inputs are load-use hazards, taken branches resolved in EX, jumps resolved in ID, and an external interrupt. A small FSM sequences interrupt entry, kernel mode and return (`eret`), and holds the EPC. It sits beside the decoder and drives the `flush` input of the ID/EX register directly.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 15 +
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 19 +
 rtl/pipe_hazard_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline package: hazard-controller state encoding, interrupt vector
// default and the register-zero constant.
// Ports: none (types and constants only).
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_IRQ_WAIT = 2'd1,
        ST_KERNEL   = 2'd2
    } hz_state_t;

    localparam logic [31:0] IRQ_VECTOR_DEFAULT = 32'h8000_0004;
    localparam logic [4:0]  REG_ZERO           = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use compare: a load in EX writes a register the ID instruction reads.
// Ports: ex_mem_read/ex_rt describe the EX load; id_rs/id_rt/id_uses_rt describe ID sources;
//        hazard is high when ID must wait one cycle for the load data.
module load_use_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       hazard
);

    // A load targeting r0 never produces a value, so it can never create a hazard.
    assign hazard = ex_mem_read && (ex_rt != REG_ZERO) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: PC / IF-ID / ID-EX enables and flushes, plus
// interrupt entry, kernel mode and eret return with EPC (only when PIPE_HAZARD_CTRL_IRQ_EN
// is defined; otherwise irq, id_eret and id_valid are ignored and the state stays RUN).
// Ports: hazard sources in (load in EX, branch in EX, jump/eret in ID, irq); enables,
//        flushes, redirect/redirect_pc, kernel and epc out. All controls are zero-latency.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter logic [31:0] IRQ_VECTOR = IRQ_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_jump,
    input  logic        id_eret,
    input  logic [31:0] id_pc_plus_4,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        irq,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        kernel,
    output logic [31:0] epc
);

    logic lu;

    load_use_detect u_lu (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .hazard      (lu)
    );

`ifdef PIPE_HAZARD_CTRL_IRQ_EN
    hz_state_t   state;
    logic [31:0] epc_q;
    logic        irq_take;
    logic        eret_take;

    // Entry needs a real ID instruction to become the EPC, and must not race a
    // branch flush or a stalled (not yet issuable) ID instruction.
    assign irq_take  = ((state == ST_RUN) || (state == ST_IRQ_WAIT)) && irq &&
                       id_valid && !lu && !ex_branch_taken;
    assign eret_take = (state == ST_KERNEL) && id_eret && id_valid &&
                       !lu && !ex_branch_taken;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            epc_q <= 32'h0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (irq_take) begin
                        state <= ST_KERNEL;
                        epc_q <= id_pc_plus_4 - 32'd4;
                    end else if (irq) begin
                        state <= ST_IRQ_WAIT;
                    end
                end
                ST_IRQ_WAIT: begin
                    if (irq_take) begin
                        state <= ST_KERNEL;
                        epc_q <= id_pc_plus_4 - 32'd4;
                    end else if (!irq) begin
                        state <= ST_RUN;
                    end
                end
                ST_KERNEL: begin
                    if (eret_take) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign kernel = (state == ST_KERNEL);
    assign epc    = epc_q;
`else
    // Interrupt path compiled out; these inputs are intentionally left unused.
    logic unused_irq_inputs;
    assign unused_irq_inputs = &{1'b0, id_valid, id_eret, irq, id_pc_plus_4};
    assign kernel = 1'b0;
    assign epc    = 32'h0;
`endif

    // Priority chain: branch > irq entry > load-use > eret > jump > normal.
    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        redirect    = 1'b0;
        redirect_pc = IRQ_VECTOR;
        if (!reset) begin
            // Freeze the front end while reset is held.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
`ifdef PIPE_HAZARD_CTRL_IRQ_EN
        end else if (irq_take) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            redirect    = 1'b1;
`endif
        end else if (lu) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
`ifdef PIPE_HAZARD_CTRL_IRQ_EN
        end else if (eret_take) begin
            redirect    = 1'b1;
            redirect_pc = epc_q;
            if_id_flush = 1'b1;
`endif
        end else if (id_jump) begin
            if_id_flush = 1'b1;
        end
    end

endmodule
